// File: rtl/ask_deserializer.sv
// rtl/ask_deserializer.sv - mid-bit sampling deserializer for the recovered ASK bit stream
// Frames start on new_word; a new_word during reception aborts and restarts the frame.
module ask_deserializer #(
  parameter int WORD_W = 10,
  parameter int CPB    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              new_word,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int CW = $clog2(CPB);
  localparam int BW = $clog2(WORD_W);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // cyc_q holds (cycle - 1) mod CPB, so the mid-bit sample lands on CPB/2-1.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (new_word) begin
      err_d   = (state_q == SHIFT);
      state_d = SHIFT;
      cyc_d   = '0;
      bit_d   = '0;
      shift_d = '0;
    end else if (state_q == SHIFT) begin
      if (cyc_q == CW'(CPB - 1)) begin
        cyc_d = '0;
        bit_d = bit_q + 1'b1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
      if (cyc_q == CW'(CPB / 2 - 1)) begin
        shift_d = {shift_q[WORD_W-2:0], din};
        // Last bit: publish now and drop the trailing half-bit.
        if (bit_q == BW'(WORD_W - 1)) begin
          word_d  = shift_d;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ask_deserializer.sv
// tb/tb_ask_deserializer.sv - testbench for ask_deserializer
module tb_ask_deserializer;
  localparam int W   = 10;
  localparam int CPB = 16;
  localparam int FRAME_LEN = (W - 1) * CPB + CPB / 2 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         new_word = 1'b0;
  logic [W-1:0] word;
  logic         word_valid, busy, frame_err;
  logic [7:0]   frame_cnt;

  ask_deserializer #(.WORD_W(W), .CPB(CPB)) dut (
    .clk(clk), .rst(rst), .din(din), .new_word(new_word),
    .word(word), .word_valid(word_valid), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference: frame described by its start cycle; bit k sampled at offset k*CPB + CPB/2.
  bit           m_in = 0;
  int           m_start = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_word = '0;
  logic [7:0]   m_cnt = '0;
  bit           m_valid = 0;
  bit           m_err = 0;

  typedef struct {
    logic [W-1:0] data;
    int           pre;
    bit           glitch;
    logic [W-1:0] exp_word;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_step(input bit nw, input bit d);
    int off;
    m_valid = 0;
    m_err   = 0;
    if (nw) begin
      m_err   = m_in;
      m_in    = 1;
      m_start = t;
      m_acc   = '0;
    end else if (m_in) begin
      off = t - m_start;
      if (off % CPB == CPB / 2) begin
        m_acc = (m_acc << 1) | W'(d);
        if (off / CPB == W - 1) begin
          m_word  = m_acc;
          m_cnt   = m_cnt + 8'd1;
          m_valid = 1;
          m_in    = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("word", 32'(word), 32'(m_word));
    check("word_valid", 32'(word_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_in));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic cyc(input bit nw, input bit d);
    new_word = nw;
    din      = d;
    @(posedge clk);
    model_step(nw, d);
    t++;
    #1;
    check_all();
  endtask

  task automatic send(input logic [W-1:0] data, input bit glitch, input int len);
    for (int c = 0; c < len; c++) begin
      int k;
      bit d;
      k = c / CPB;
      d = (k < W) ? data[W-1-k] : 1'b0;
      if (glitch && (c % CPB) < CPB / 2) d = 1'($urandom);
      cyc(c == 0, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_in = 0; m_acc = '0; m_word = '0; m_cnt = '0; m_valid = 0; m_err = 0;
    check("rst_word", 32'(word), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t++;
  endtask

  initial begin
    vecs[0] = '{data: 10'h2A5, pre: 0,  glitch: 0, exp_word: 10'h2A5, exp_cnt: 8'd1};
    vecs[1] = '{data: 10'h3FF, pre: 0,  glitch: 0, exp_word: 10'h3FF, exp_cnt: 8'd2};
    vecs[2] = '{data: 10'h000, pre: 0,  glitch: 0, exp_word: 10'h000, exp_cnt: 8'd3};
    vecs[3] = '{data: 10'h155, pre: 80, glitch: 0, exp_word: 10'h155, exp_cnt: 8'd4};
    vecs[4] = '{data: 10'h2A5, pre: 0,  glitch: 1, exp_word: 10'h2A5, exp_cnt: 8'd5};
    vecs[5] = '{data: 10'h0CC, pre: 5,  glitch: 1, exp_word: 10'h0CC, exp_cnt: 8'd6};

    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1'($urandom));

    // Directed frames; entries 1 and 2 are back-to-back (new_word in the word_valid cycle).
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre > 0) send(W'($urandom), 0, vecs[i].pre);
      send(vecs[i].data, vecs[i].glitch, FRAME_LEN);
      check("vec_word", 32'(word), 32'(vecs[i].exp_word));
      check("vec_cnt", 32'(frame_cnt), 32'(vecs[i].exp_cnt));
      check("vec_valid", 32'(word_valid), 32'd1);
    end

    // Reset in cycle 70 of a frame: everything clears, nothing follows until new_word.
    send(10'h1E3, 0, 70);
    do_reset();
    for (int i = 0; i < 200; i++) cyc(0, 1'($urandom));
    check("post_rst_word", 32'(word), 32'd0);

    // Random frames, gaps, glitches and aborts; 256 completions wrap frame_cnt to 0.
    for (int n = 0; n < 256; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cyc(0, 1'($urandom));
      if ($urandom_range(0, 15) == 0) send(W'($urandom), 0, $urandom_range(1, FRAME_LEN - 1));
      send(W'($urandom), 1'($urandom), FRAME_LEN);
    end
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
